neuron_accumulator: RTL and testbench

- Downstream consumer of the registered pairwise adder stage in the neuron datapath.
- Collects N_TERMS adder results, each a 17-bit partial sum of two 16-bit products, into one neuron pre-activation sum.
- Applies a fixed right-shift scaling and unsigned saturation to the output width, then presents the result on a valid/ready handshake to the activation stage.

---
 rtl/neuron_accumulator.sv | 115 +++++++++++
 tb/tb_neuron_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums N_TERMS partial sums from the pairwise adder stage,
// scales the total by a logical right shift, saturates it to OUT_W bits and
// hands the result to the activation stage over a valid/ready handshake.
module neuron_accumulator #(
    parameter int IN_W    = 17,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 0,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TERMS - 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             acc_sat;

    logic [SUM_W-1:0] sum_w;
    logic [ACC_W-1:0] acc_next;
    logic             acc_sat_next;
    logic [ACC_W-1:0] shifted;
    logic             clip;
    logic [OUT_W-1:0] out_next;

    // Next accumulator value with sticky overflow, plus the scaled/clipped result
    always_comb begin
        sum_w        = SUM_W'(acc) + SUM_W'(in_data);
        acc_next     = sum_w[ACC_W-1:0];
        acc_sat_next = acc_sat;
        if (sum_w[ACC_W]) begin
            acc_next     = '1;
            acc_sat_next = 1'b1;
        end
        shifted  = acc_next >> SHIFT;
        clip     = (shifted >> OUT_W) != '0;
        out_next = clip ? '1 : shifted[OUT_W-1:0];
    end

    // Control FSM, accumulator and registered result; abort overrides all events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            count     <= '0;
            acc_sat   <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            acc       <= '0;
            count     <= '0;
            acc_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        count   <= '0;
                        acc_sat <= 1'b0;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc     <= acc_next;
                        acc_sat <= acc_sat_next;
                        count   <= count + 1'b1;
                        if (count == LAST_BEAT) begin
                            out_data  <= out_next;
                            out_sat   <= acc_sat_next | clip;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status flags decoded from state
    always_comb begin
        in_ready = (state == S_ACCUM);
        busy     = (state != S_IDLE);
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: four differently parameterised
// instances share stimulus; start is steered to the instance under test.
module tb_neuron_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [16:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        st    [4];
    logic        ir    [4];
    logic [15:0] od    [4];
    logic        os    [4];
    logic        ov    [4];
    logic        bz    [4];

    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic [16:0] exp_q [$];
    logic [16:0] stim  [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) st[i] = start && (sel == i);
    end

    // 0: defaults; 1: SHIFT=4; 2: N_TERMS=1; 3: ACC_W=17, N_TERMS=2
    neuron_accumulator #(.IN_W(17), .N_TERMS(4), .ACC_W(24), .SHIFT(0), .OUT_W(16)) u0 (
        .clk(clk), .reset(reset), .start(st[0]), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir[0]), .out_data(od[0]), .out_sat(os[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]));
    neuron_accumulator #(.IN_W(17), .N_TERMS(4), .ACC_W(24), .SHIFT(4), .OUT_W(16)) u1 (
        .clk(clk), .reset(reset), .start(st[1]), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir[1]), .out_data(od[1]), .out_sat(os[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]));
    neuron_accumulator #(.IN_W(17), .N_TERMS(1), .ACC_W(24), .SHIFT(0), .OUT_W(16)) u2 (
        .clk(clk), .reset(reset), .start(st[2]), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir[2]), .out_data(od[2]), .out_sat(os[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]));
    neuron_accumulator #(.IN_W(17), .N_TERMS(2), .ACC_W(17), .SHIFT(0), .OUT_W(16)) u3 (
        .clk(clk), .reset(reset), .start(st[3]), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_ready(ir[3]), .out_data(od[3]), .out_sat(os[3]),
        .out_valid(ov[3]), .out_ready(out_ready), .busy(bz[3]));

    // Scoreboard: compare each result at the cycle its handshake fires
    always @(negedge clk) begin
        if (ov[sel] && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result dut=%0d got sat=%b data=%h, required no output",
                         sel, os[sel], od[sel]);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({os[sel], od[sel]} !== e) begin
                    errors++;
                    $display("FAIL result dut=%0d got sat=%b data=%h, required sat=%b data=%h",
                             sel, os[sel], od[sel], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start a neuron and feed stim; if complete, queue expd and check latency
    task automatic run(input int gap, input bit complete, input logic [16:0] expd);
        int n;
        do_start();
        for (int i = 0; i < stim.size(); i++) begin
            in_data  = stim[i];
            in_valid = 1'b1;
            n = 0;
            while (!ir[sel] && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (!ir[sel]) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout dut=%0d got 0, required 1", sel);
            end
            if (complete && i == stim.size() - 1) exp_q.push_back(expd);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = $urandom_range(0, 17'h1FFFF);
            if (complete && i == stim.size() - 1) begin
                checks++;
                if (ov[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL latency dut=%0d out_valid got %b, required 1", sel, ov[sel]);
                end
            end else begin
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout dut=%0d pending got %0d, required 0", sel, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        checks++;
        if (bz[sel] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_handshake dut=%0d got %b, required 0", sel, bz[sel]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({od[i], os[i], ov[i], ir[i], bz[i]} !== 20'd0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got data=%h sat=%b valid=%b ready=%b busy=%b, required all 0",
                         i, od[i], os[i], ov[i], ir[i], bz[i]);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        sel = 0;
        stim = '{17'd100, 17'd200, 17'd300, 17'd400};
        run(0, 1'b1, {1'b0, 16'd1000});
        wait_drain();
    endtask

    task automatic test_gap_backpressure();
        sel = 0;
        out_ready = 1'b0;
        stim = '{17'd100, 17'd200, 17'd300, 17'd400};
        run(2, 1'b1, {1'b0, 16'd1000});
        for (int c = 0; c < 5; c++) begin
            if (c == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 16'd1000 || ir[0] !== 1'b0 || bz[0] !== 1'b1) begin
                errors++;
                $display("FAIL done_hold cyc=%0d got valid=%b data=%0d ready=%b busy=%b, required 1 1000 0 1",
                         c, ov[0], od[0], ir[0], bz[0]);
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_on_handshake got busy=%b valid=%b, required 0 0", bz[0], ov[0]);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bz[0] !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL no_second_result got busy=%b pending=%0d, required 0 0", bz[0], exp_q.size());
        end
    endtask

    task automatic test_saturation();
        stim = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
        sel = 0;
        run(0, 1'b1, {1'b1, 16'hFFFF});
        wait_drain();
        sel = 1;
        run(1, 1'b1, {1'b0, 16'h7FFF});
        wait_drain();
    endtask

    task automatic test_single_term();
        sel = 2;
        stim = '{17'h00ABC};
        run(0, 1'b1, {1'b0, 16'h0ABC});
        wait_drain();
    endtask

    task automatic test_abort_reset();
        sel = 0;
        stim = '{17'd10, 17'd20};
        run(0, 1'b0, '0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (bz[0] !== 1'b0 || ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort got busy=%b valid=%b ready=%b, required 0 0 0", bz[0], ov[0], ir[0]);
        end
        stim = '{17'd1, 17'd2, 17'd3, 17'd4};
        run(0, 1'b1, {1'b0, 16'd10});
        wait_drain();

        stim = '{17'd10, 17'd20};
        run(0, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({od[0], os[0], ov[0], ir[0], bz[0]} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset got data=%h sat=%b valid=%b ready=%b busy=%b, required all 0",
                     od[0], os[0], ov[0], ir[0], bz[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        stim = '{17'd1, 17'd2, 17'd3, 17'd4};
        run(0, 1'b1, {1'b0, 16'd10});
        wait_drain();
    endtask

    task automatic test_acc_stick();
        sel = 3;
        stim = '{17'h1FFFF, 17'h00001};
        run(0, 1'b1, {1'b1, 16'hFFFF});
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap_backpressure();
        test_saturation();
        test_single_term();
        test_abort_reset();
        test_acc_stick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
